// File: rtl/aurora_frame_checker.sv
// Aurora RX frame checker: verifies an LFSR payload stream and frame lengths,
// counting erroneous beats (saturating) and completed frames (wrapping).
module aurora_frame_checker #(
  parameter logic [15:0] SEED        = 16'hABCD,
  parameter int unsigned FRAME_WORDS = 8
) (
  input  logic        user_clk,
  input  logic        peripheral_aresetn,
  input  logic        channel_up,
  input  logic [15:0] s_axi_rx_tdata,
  input  logic        s_axi_rx_tvalid,
  input  logic        s_axi_rx_tlast,
  input  logic        err_clear,
  output logic [3:0]  error_count,
  output logic [15:0] frame_count,
  output logic        data_err_pulse,
  output logic        checking
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ERR_W  = 4;
  localparam int unsigned FRM_W  = 16;

  localparam logic [0:0] ST_DOWN  = 1'b0;
  localparam logic [0:0] ST_CHECK = 1'b1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] x);
    return {x[14:0], x[15] ^ x[4] ^ x[3] ^ x[2]};
  endfunction

  logic [0:0]        state, state_nxt;
  logic [DATA_W-1:0] expected, expected_nxt;
  logic [CNT_W-1:0]  word_cnt, word_cnt_nxt;
  logic [ERR_W-1:0]  error_count_nxt;
  logic [FRM_W-1:0]  frame_count_nxt;
  logic              data_err_pulse_nxt;
  logic              checking_nxt;
  logic [1:0]        rst_sync;
  logic              run_c;
  logic              beat_c;
  logic              last_idx_c;
  logic              bad_c;

  // Reset release is resynchronised; logic stays frozen until it propagates.
  always_ff @(posedge user_clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) rst_sync <= 2'b00;
    else                     rst_sync <= {rst_sync[0], 1'b1};
  end

  always_comb begin
    state_nxt          = state;
    expected_nxt       = expected;
    word_cnt_nxt       = word_cnt;
    error_count_nxt    = error_count;
    frame_count_nxt    = frame_count;
    data_err_pulse_nxt = 1'b0;
    run_c              = rst_sync[1];
    beat_c             = 1'b0;
    last_idx_c         = 1'b0;
    bad_c              = 1'b0;

    if (run_c) begin
      beat_c     = (state == ST_CHECK) && s_axi_rx_tvalid && channel_up;
      last_idx_c = (word_cnt == LAST_IDX);
      bad_c      = beat_c && ((s_axi_rx_tdata != expected) || (s_axi_rx_tlast != last_idx_c));

      if (!channel_up) begin
        state_nxt    = ST_DOWN;
        expected_nxt = SEED;
        word_cnt_nxt = '0;
      end else if (state == ST_DOWN) begin
        state_nxt    = ST_CHECK;
        expected_nxt = SEED;
        word_cnt_nxt = '0;
      end else if (s_axi_rx_tvalid) begin
        // Reseeding from received data lets the checker resync after one bad word.
        expected_nxt = lfsr_next(s_axi_rx_tdata);
        word_cnt_nxt = (s_axi_rx_tlast || last_idx_c) ? '0 : word_cnt + CNT_W'(1);
        if (s_axi_rx_tlast) frame_count_nxt = frame_count + FRM_W'(1);
      end

      if (err_clear)                         error_count_nxt = bad_c ? ERR_W'(1) : '0;
      else if (bad_c && error_count != ERR_MAX) error_count_nxt = error_count + ERR_W'(1);

      data_err_pulse_nxt = bad_c;
    end

    checking_nxt = (state_nxt == ST_CHECK);
  end

  always_ff @(posedge user_clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      state          <= ST_DOWN;
      expected       <= SEED;
      word_cnt       <= '0;
      error_count    <= '0;
      frame_count    <= '0;
      data_err_pulse <= 1'b0;
      checking       <= 1'b0;
    end else begin
      state          <= state_nxt;
      expected       <= expected_nxt;
      word_cnt       <= word_cnt_nxt;
      error_count    <= error_count_nxt;
      frame_count    <= frame_count_nxt;
      data_err_pulse <= data_err_pulse_nxt;
      checking       <= checking_nxt;
    end
  end

endmodule

// File: tb/tb_aurora_frame_checker.sv
// Directed bench for aurora_frame_checker: cycle-level behavioural model plus
// hand-computed milestone expectations for each traffic scenario.
module tb_aurora_frame_checker;

  localparam logic [15:0] SEED = 16'hABCD;
  localparam int          FW   = 8;

  logic        user_clk;
  logic        peripheral_aresetn;
  logic        channel_up;
  logic [15:0] s_axi_rx_tdata;
  logic        s_axi_rx_tvalid;
  logic        s_axi_rx_tlast;
  logic        err_clear;
  logic [3:0]  error_count;
  logic [15:0] frame_count;
  logic        data_err_pulse;
  logic        checking;

  aurora_frame_checker #(.SEED(SEED), .FRAME_WORDS(FW)) dut (
    .user_clk          (user_clk),
    .peripheral_aresetn(peripheral_aresetn),
    .channel_up        (channel_up),
    .s_axi_rx_tdata    (s_axi_rx_tdata),
    .s_axi_rx_tvalid   (s_axi_rx_tvalid),
    .s_axi_rx_tlast    (s_axi_rx_tlast),
    .err_clear         (err_clear),
    .error_count       (error_count),
    .frame_count       (frame_count),
    .data_err_pulse    (data_err_pulse),
    .checking          (checking)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Model state: link checked, next expected word, position in frame, counters.
  logic        m_chk;
  logic [15:0] m_exp;
  int          m_idx;
  int          m_err;
  int          m_frm;
  logic        m_pulse;
  logic [15:0] gen;

  function automatic logic [15:0] lfsr(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[4] ^ x[3] ^ x[2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_chk = 1'b0; m_exp = SEED; m_idx = 0; m_err = 0; m_frm = 0; m_pulse = 1'b0;
  endtask

  task automatic compare_all();
    check("checking", 32'(checking), 32'(m_chk));
    check("error_count", 32'(error_count), 32'(m_err));
    check("frame_count", 32'(frame_count), 32'(m_frm));
    check("data_err_pulse", 32'(data_err_pulse), 32'(m_pulse));
    if (data_err_pulse === 1'b1) pulses++;
  endtask

  // One clock: apply inputs, advance the model on the edge, compare after it.
  task automatic step(input logic cu, input logic v, input logic [15:0] d,
                      input logic l, input logic clr);
    bit beat, bad;
    channel_up = cu; s_axi_rx_tvalid = v; s_axi_rx_tdata = d;
    s_axi_rx_tlast = l; err_clear = clr;
    @(posedge user_clk);
    if (!peripheral_aresetn) model_reset();
    else begin
      beat = m_chk && cu && v;
      bad  = 1'b0;
      if (beat) begin
        bad   = (d !== m_exp) || (l != (m_idx == FW - 1));
        m_exp = lfsr(d);
        if (l) m_frm = (m_frm + 1) % 65536;
        m_idx = (l || m_idx == FW - 1) ? 0 : m_idx + 1;
      end
      if (!cu || !m_chk) begin m_exp = SEED; m_idx = 0; end
      if (clr) m_err = bad ? 1 : 0;
      else if (bad) m_err = (m_err < 15) ? m_err + 1 : 15;
      m_pulse = bad;
      m_chk   = cu;
    end
    #1 compare_all();
  endtask

  task automatic beat(input logic [15:0] mask, input logic l, input logic clr);
    logic [15:0] d;
    d = gen ^ mask;
    step(1'b1, 1'b1, d, l, clr);
    gen = lfsr(d);
  endtask

  task automatic idle(input logic cu, input logic l);
    step(cu, 1'b0, 16'($urandom), l, 1'b0);
  endtask

  task automatic frame_clean(input int n);
    for (int i = 0; i < n; i++) beat(16'h0, 1'(i == n - 1), 1'b0);
  endtask

  // Asynchronous assert, checked before any clock edge, then bring the link up.
  task automatic do_reset();
    peripheral_aresetn = 1'b0;
    channel_up = 1'b0; s_axi_rx_tvalid = 1'b0; err_clear = 1'b0;
    model_reset();
    #1;
    check("rst_checking", 32'(checking), 32'h0);
    check("rst_error_count", 32'(error_count), 32'h0);
    check("rst_frame_count", 32'(frame_count), 32'h0);
    check("rst_pulse", 32'(data_err_pulse), 32'h0);
    repeat (2) idle(1'b0, 1'b0);
    peripheral_aresetn = 1'b1;
    repeat (3) idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    check("link_up_checking", 32'(checking), 32'h1);
    gen = SEED;
  endtask

  int p0;

  initial begin
    peripheral_aresetn = 1'b0;
    channel_up = 1'b0; s_axi_rx_tvalid = 1'b0; s_axi_rx_tdata = '0;
    s_axi_rx_tlast = 1'b0; err_clear = 1'b0;
    gen = SEED;
    model_reset();

    check("lfsr_seed_step", 32'(lfsr(SEED)), 32'h579B);
    do_reset();

    // Clean frames; the middle one has idle gaps with tlast held high.
    frame_clean(FW);
    for (int i = 0; i < FW; i++) begin
      beat(16'h0, 1'(i == FW - 1), 1'b0);
      if (i == 2 || i == 5) idle(1'b1, 1'b1);
    end
    frame_clean(FW);
    check("clean_frames", 32'(frame_count), 32'd3);
    check("clean_errors", 32'(error_count), 32'd0);
    check("clean_pulses", 32'(pulses), 32'd0);

    // Single corrupted word, followed by a frame that must resync cleanly.
    p0 = pulses;
    for (int i = 0; i < FW; i++) beat((i == 2) ? 16'h0001 : 16'h0, 1'(i == FW - 1), 1'b0);
    frame_clean(FW);
    check("corrupt_errors", 32'(error_count), 32'd1);
    check("corrupt_pulses", 32'(pulses - p0), 32'd1);
    check("corrupt_frames", 32'(frame_count), 32'd5);

    // Short frame: early tlast is one error. 9-beat frame: missing tlast at
    // beat 8 and then a tlast at word 0 on beat 9 are one error each.
    for (int i = 0; i < 5; i++) beat(16'h0, 1'(i == 4), 1'b0);
    check("short_frame_errors", 32'(error_count), 32'd2);
    for (int i = 0; i < 9; i++) beat(16'h0, 1'(i == 8), 1'b0);
    check("len_errors", 32'(error_count), 32'd4);
    check("len_frames", 32'(frame_count), 32'd7);
    frame_clean(FW);
    check("after_len_errors", 32'(error_count), 32'd4);

    // Saturation, then clear coinciding with an error, then a plain clear.
    p0 = pulses;
    for (int i = 0; i < 20; i++) beat(16'h0001, 1'(i % FW == FW - 1), 1'b0);
    check("saturated", 32'(error_count), 32'hF);
    check("saturated_pulses", 32'(pulses - p0), 32'd20);
    beat(16'h0001, 1'b0, 1'b1);
    check("clear_with_error", 32'(error_count), 32'd1);
    beat(16'h0, 1'b0, 1'b1);
    check("clear_alone", 32'(error_count), 32'd0);
    beat(16'h0, 1'b0, 1'b0);
    beat(16'h0, 1'b1, 1'b0);
    check("sat_frames", 32'(frame_count), 32'd11);

    // Link drop mid-frame with junk beats; restart from SEED.
    for (int i = 0; i < 3; i++) beat(16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'($urandom), 1'(i == 1), 1'b0);
    check("drop_checking", 32'(checking), 32'h0);
    idle(1'b1, 1'b0);
    gen = SEED;
    frame_clean(FW);
    check("drop_errors", 32'(error_count), 32'd0);
    check("drop_frames", 32'(frame_count), 32'd12);

    // Build error_count=5, frame_count=7, then reset mid-frame.
    do_reset();
    for (int f = 0; f < 7; f++)
      for (int i = 0; i < FW; i++)
        beat((f < 5 && i == 1) ? 16'h0100 : 16'h0, 1'(i == FW - 1), 1'b0);
    check("pre_reset_errors", 32'(error_count), 32'd5);
    check("pre_reset_frames", 32'(frame_count), 32'd7);
    for (int i = 0; i < 3; i++) beat(16'h0, 1'b0, 1'b0);
    #2;
    do_reset();
    frame_clean(FW);
    check("restart_frames", 32'(frame_count), 32'd1);
    check("restart_errors", 32'(error_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
